room_sequencer: RTL

ROOM_SEQUENCER -- requirements
Module: room_sequencer

---
 rtl/room_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/room_sequencer.sv
// Room/respawn sequencer: death delay, fade-out, room swap, fade-in and victory hold.
// Optional death counter is enabled by defining ROOM_SEQUENCER_DEATH_COUNT_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   PLAY      | player free, screen clear, exits/checkpoints accepted
//   DYING     | player frozen for 16 frame ticks after a spike hit
//   FADE_OUT  | screen darkens one level per frame tick up to black
//   SWAP      | single cycle: load target room, pulse respawn
//   FADE_IN   | screen brightens one level per frame tick back to clear
//   WIN       | victory screen held black until restart
module room_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       restart_i,
  input  logic       hit_spike_i,
  input  logic       hit_check_i,
  input  logic [9:0] check_x_i,
  input  logic [9:0] check_y_i,
  input  logic [1:0] exit_req_i,
  output logic [1:0] inmap_o,
  output logic [9:0] spawn_x_o,
  output logic [9:0] spawn_y_o,
  output logic       respawn_o,
  output logic       freeze_o,
  output logic [2:0] fade_o,
  output logic       victory_o,
  output logic [7:0] deaths_o
);

  localparam logic [2:0] ST_PLAY     = 3'd0;
  localparam logic [2:0] ST_DYING    = 3'd1;
  localparam logic [2:0] ST_FADE_OUT = 3'd2;
  localparam logic [2:0] ST_SWAP     = 3'd3;
  localparam logic [2:0] ST_FADE_IN  = 3'd4;
  localparam logic [2:0] ST_WIN      = 3'd5;

  localparam logic [1:0] ROOM_MAP0 = 2'b00;
  localparam logic [1:0] ROOM_MAP1 = 2'b01;
  localparam logic [1:0] ROOM_VICT = 2'b10;

  localparam logic [9:0] MAP0_X = 10'd32;
  localparam logic [9:0] MAP0_Y = 10'd224;
  localparam logic [9:0] MAP1_X = 10'd0;
  localparam logic [9:0] MAP1_Y = 10'd32;
  localparam logic [9:0] VICT_X = 10'd0;
  localparam logic [9:0] VICT_Y = 10'd0;

  localparam logic [3:0] DYING_TICKS_M1 = 4'd15;
  localparam logic [2:0] FADE_BLACK     = 3'd7;

  logic [2:0] state_q, state_d;
  logic [1:0] inmap_q, inmap_d;
  logic [1:0] target_q, target_d;
  logic [9:0] spawn_x_q, spawn_x_d;
  logic [9:0] spawn_y_q, spawn_y_d;
  logic [2:0] fade_q, fade_d;
  logic [3:0] dly_q, dly_d;

  function automatic logic [1:0] exit_target(input logic [1:0] req);
    logic [1:0] t;
    case (req)
      2'b01:   t = ROOM_MAP1;
      2'b10:   t = ROOM_MAP0;
      default: t = ROOM_VICT;
    endcase
    return t;
  endfunction

  function automatic logic [19:0] room_default(input logic [1:0] room);
    logic [19:0] xy;
    case (room)
      ROOM_MAP0: xy = {MAP0_X, MAP0_Y};
      ROOM_MAP1: xy = {MAP1_X, MAP1_Y};
      default:   xy = {VICT_X, VICT_Y};
    endcase
    return xy;
  endfunction

  always_comb begin
    state_d   = state_q;
    inmap_d   = inmap_q;
    target_d  = target_q;
    spawn_x_d = spawn_x_q;
    spawn_y_d = spawn_y_q;
    fade_d    = fade_q;
    dly_d     = dly_q;

    case (state_q)
      ST_PLAY: begin
        if (hit_spike_i) begin
          state_d = ST_DYING;
          dly_d   = DYING_TICKS_M1;
        end else if (exit_req_i != 2'b00) begin
          state_d  = ST_FADE_OUT;
          fade_d   = 3'd0;
          target_d = exit_target(exit_req_i);
        end else if (hit_check_i) begin
          spawn_x_d = check_x_i;
          spawn_y_d = check_y_i;
        end
      end
      ST_DYING: begin
        if (frame_tick_i) begin
          if (dly_q == 4'd0) begin
            state_d  = ST_FADE_OUT;
            fade_d   = 3'd0;
            target_d = inmap_q;
          end else begin
            dly_d = dly_q - 4'd1;
          end
        end
      end
      ST_FADE_OUT: begin
        if (frame_tick_i) begin
          if (fade_q == FADE_BLACK) state_d = ST_SWAP;
          else                      fade_d  = fade_q + 3'd1;
        end
      end
      ST_SWAP: begin
        inmap_d = target_q;
        // Re-entering the same room keeps the last checkpoint.
        if (target_q != inmap_q) {spawn_x_d, spawn_y_d} = room_default(target_q);
        state_d = (target_q == ROOM_VICT) ? ST_WIN : ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (frame_tick_i) begin
          if (fade_q == 3'd0) state_d = ST_PLAY;
          else                fade_d  = fade_q - 3'd1;
        end
      end
      ST_WIN: begin
      end
      default: state_d = ST_PLAY;
    endcase

    // Restart overrides every state; the fade level is left where it was.
    if (restart_i) begin
      state_d   = ST_SWAP;
      target_d  = ROOM_MAP0;
      spawn_x_d = MAP0_X;
      spawn_y_d = MAP0_Y;
      fade_d    = fade_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_PLAY;
      inmap_q   <= ROOM_MAP0;
      target_q  <= ROOM_MAP0;
      spawn_x_q <= MAP0_X;
      spawn_y_q <= MAP0_Y;
      fade_q    <= 3'd0;
      dly_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      inmap_q   <= inmap_d;
      target_q  <= target_d;
      spawn_x_q <= spawn_x_d;
      spawn_y_q <= spawn_y_d;
      fade_q    <= fade_d;
      dly_q     <= dly_d;
    end
  end

`ifdef ROOM_SEQUENCER_DEATH_COUNT_EN
  logic [7:0] deaths_q, deaths_d;

  always_comb begin
    deaths_d = deaths_q;
    if (restart_i)
      deaths_d = 8'd0;
    else if (state_q == ST_PLAY && hit_spike_i && deaths_q != 8'hFF)
      deaths_d = deaths_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) deaths_q <= 8'd0;
    else       deaths_q <= deaths_d;
  end

  assign deaths_o = deaths_q;
`else
  assign deaths_o = 8'd0;
`endif

  assign inmap_o   = inmap_q;
  assign spawn_x_o = spawn_x_q;
  assign spawn_y_o = spawn_y_q;
  assign respawn_o = (state_q == ST_SWAP);
  assign freeze_o  = (state_q != ST_PLAY);
  assign victory_o = (state_q == ST_WIN);
  assign fade_o    = (state_q == ST_WIN)  ? FADE_BLACK :
                     (state_q == ST_PLAY) ? 3'd0 : fade_q;

endmodule
